dealer_communication: RTL and testbench

Dealer-side counterpart of the player communication handshake. It accepts a "query player N" command from the dealer game FSM and drives `request_player` to the selected player. It captures that player's `action`/`bet` on `valid`, acknowledges the player, and returns one validated decision record to the game FSM. It also enforces a response timeout and flushes stray player responses so that no player handshake can deadlock.

---
 rtl/poker_pkg.sv | 19 +
 rtl/dealer_communication_response_checker.sv | 16 +
 rtl/dealer_communication.sv | 161 ++++++++++++++++
 tb/tb_dealer_communication.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// Shared poker definitions: action codes, dealer handshake states, bet width.
package poker_pkg;

   localparam int BET_W = 8;

   localparam logic [2:0] ACT_FOLD   = 3'd0;
   localparam logic [2:0] ACT_CHECK  = 3'd1;
   localparam logic [2:0] ACT_CALL   = 3'd2;
   localparam logic [2:0] ACT_RAISE  = 3'd3;
   localparam logic [2:0] ACT_ALL_IN = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_ACK     = 2'd2,
      ST_TOUT    = 2'd3
   } state_t;

endpackage

// File: rtl/dealer_communication_response_checker.sv
// Combinational legality check of one captured player decision.
module response_checker
   import poker_pkg::*;
(
   input  logic [2:0]       action,
   input  logic [BET_W-1:0] bet,
   input  logic [BET_W-1:0] min_bet,
   output logic             illegal
);

   // Codes above ALL_IN are undefined; a raise must meet the latched minimum.
   always_comb begin
      illegal = (action > ACT_ALL_IN) || ((action == ACT_RAISE) && (bet < min_bet));
   end

endmodule

// File: rtl/dealer_communication.sv
// Dealer side of the player handshake: query one player, capture its
// decision, enforce a response timeout and flush stray responders.
module dealer_communication
   import poker_pkg::*;
#(
   parameter int NUM_PLAYERS = 4,
   parameter int PW          = 2,
   parameter int TIMEOUT     = 1000
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   input  logic [PW-1:0]                  cmd_player,
   input  logic [BET_W-1:0]               min_bet,
   output logic                           cmd_ready,
   output logic [NUM_PLAYERS-1:0]         request_player,
   output logic [NUM_PLAYERS-1:0]         ack,
   input  logic [NUM_PLAYERS-1:0]         valid,
   input  logic [3*NUM_PLAYERS-1:0]       action_in,
   input  logic [BET_W*NUM_PLAYERS-1:0]   bet_in,
   output logic                           decision_valid,
   output logic [PW-1:0]                  decision_player,
   output logic [2:0]                     decision_action,
   output logic [BET_W-1:0]               decision_bet,
   output logic                           decision_timeout,
   output logic                           decision_illegal
);

   localparam logic [PW:0] NP_LIM   = (PW+1)'(NUM_PLAYERS);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t                   r_state, w_state_nxt;
   logic [PW-1:0]            r_sel;
   logic [BET_W-1:0]         r_min_bet;
   logic [15:0]              r_cnt;
   logic [2:0]               r_act;
   logic [BET_W-1:0]         r_bet;
   logic [NUM_PLAYERS-1:0]   r_flush;

   logic                     r_dec_valid;
   logic [PW-1:0]            r_dec_player;
   logic [2:0]               r_dec_action;
   logic [BET_W-1:0]         r_dec_bet;
   logic                     r_dec_timeout;
   logic                     r_dec_illegal;

   logic                     w_cmd_ok;
   logic                     w_sel_valid;
   logic                     w_tmo;
   logic                     w_illegal;
   logic [NUM_PLAYERS-1:0]   w_req;
   logic [NUM_PLAYERS-1:0]   w_ack;

   assign w_cmd_ok    = cmd_valid && ({1'b0, cmd_player} < NP_LIM);
   assign w_sel_valid = valid[r_sel];
   assign w_tmo       = (r_cnt == TMO_LAST);

   response_checker u_chk (
      .action  (r_act),
      .bet     (r_bet),
      .min_bet (r_min_bet),
      .illegal (w_illegal)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state: a response on the same edge as the timeout takes the ACK path.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_cmd_ok) w_state_nxt = ST_REQUEST;
         ST_REQUEST: begin
            if (w_sel_valid) w_state_nxt = ST_ACK;
            else if (w_tmo)  w_state_nxt = ST_TOUT;
         end
         ST_ACK:     if (!w_sel_valid) w_state_nxt = ST_IDLE;
         ST_TOUT:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, wait counter, first-valid capture and decision record.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel         <= '0;
         r_min_bet     <= '0;
         r_cnt         <= '0;
         r_act         <= '0;
         r_bet         <= '0;
         r_flush       <= '0;
         r_dec_valid   <= 1'b0;
         r_dec_player  <= '0;
         r_dec_action  <= '0;
         r_dec_bet     <= '0;
         r_dec_timeout <= 1'b0;
         r_dec_illegal <= 1'b0;
      end else begin
         r_flush     <= valid;
         r_dec_valid <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_cmd_ok) begin
               r_sel     <= cmd_player;
               r_min_bet <= min_bet;
               r_cnt     <= '0;
            end
            ST_REQUEST: begin
               r_cnt <= r_cnt + 16'd1;
               if (w_sel_valid) begin
                  r_act <= action_in[3*int'(r_sel) +: 3];
                  r_bet <= bet_in[BET_W*int'(r_sel) +: BET_W];
               end
            end
            ST_ACK: if (!w_sel_valid) begin
               r_dec_valid   <= 1'b1;
               r_dec_player  <= r_sel;
               r_dec_action  <= r_act;
               r_dec_bet     <= r_bet;
               r_dec_timeout <= 1'b0;
               r_dec_illegal <= w_illegal;
            end
            ST_TOUT: begin
               r_dec_valid   <= 1'b1;
               r_dec_player  <= r_sel;
               r_dec_action  <= ACT_FOLD;
               r_dec_bet     <= '0;
               r_dec_timeout <= 1'b1;
               r_dec_illegal <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Request/ack decode: the selected player is owned by the FSM, all others
   // (and the selected one after a timeout) echo their registered valid.
   always_comb begin
      w_req = '0;
      w_ack = r_flush;
      if (r_state == ST_REQUEST) begin
         w_req[r_sel] = 1'b1;
         w_ack[r_sel] = 1'b0;
      end else if (r_state == ST_ACK) begin
         w_ack[r_sel] = 1'b1;
      end
   end

   assign cmd_ready        = (r_state == ST_IDLE);
   assign request_player   = w_req;
   assign ack              = w_ack;
   assign decision_valid   = r_dec_valid;
   assign decision_player  = r_dec_player;
   assign decision_action  = r_dec_action;
   assign decision_bet     = r_dec_bet;
   assign decision_timeout = r_dec_timeout;
   assign decision_illegal = r_dec_illegal;

endmodule

// File: tb/tb_dealer_communication.sv
// Directed bench for dealer_communication with a transaction-level reference model.
module tb_dealer_communication;
   import poker_pkg::*;

   localparam int NP  = 4;
   localparam int PW  = 2;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid;
   logic [1:0]  cmd_player;
   logic [7:0]  min_bet;
   logic        cmd_ready;
   logic [3:0]  request_player, ack, valid;
   logic [11:0] action_in;
   logic [31:0] bet_in;
   logic        decision_valid, decision_timeout, decision_illegal;
   logic [1:0]  decision_player;
   logic [2:0]  decision_action;
   logic [7:0]  decision_bet;

   // second instance with three players for the out-of-range command
   logic        cmd_valid2;
   logic [1:0]  cmd_player2;
   logic        cmd_ready2;
   logic [2:0]  req2, ack2, valid2;
   logic [8:0]  action2;
   logic [23:0] bet2;
   logic        dv2, dto2, dill2;
   logic [1:0]  dpl2;
   logic [2:0]  dact2;
   logic [7:0]  dbet2;

   dealer_communication #(.NUM_PLAYERS(NP), .PW(PW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_player(cmd_player),
      .min_bet(min_bet), .cmd_ready(cmd_ready), .request_player(request_player),
      .ack(ack), .valid(valid), .action_in(action_in), .bet_in(bet_in),
      .decision_valid(decision_valid), .decision_player(decision_player),
      .decision_action(decision_action), .decision_bet(decision_bet),
      .decision_timeout(decision_timeout), .decision_illegal(decision_illegal)
   );

   dealer_communication #(.NUM_PLAYERS(3), .PW(2), .TIMEOUT(TMO)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_player(cmd_player2),
      .min_bet(8'd0), .cmd_ready(cmd_ready2), .request_player(req2),
      .ack(ack2), .valid(valid2), .action_in(action2), .bet_in(bet2),
      .decision_valid(dv2), .decision_player(dpl2),
      .decision_action(dact2), .decision_bet(dbet2),
      .decision_timeout(dto2), .decision_illegal(dill2)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   int dec_count = 0, last_cyc = 0, acc_cyc = 0;
   int ack1_cnt = 0, ack2_cnt = 0;
   logic [1:0] last_player;
   logic [2:0] last_action;
   logic [7:0] last_bet;
   logic       last_to, last_ill;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // busy: a query is outstanding; resp: the player answered; tout: gave up.
   bit         m_busy = 0, m_resp = 0, m_tout = 0, m_dv = 0, m_dto = 0, m_dill = 0;
   int         m_wait = 0;
   logic [1:0] m_sel = '0, m_dplayer = '0;
   logic [7:0] m_minb = '0, m_bet = '0, m_dbet = '0;
   logic [2:0] m_act = '0, m_dact = '0;
   logic [3:0] m_stray = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0; m_resp = 0; m_tout = 0; m_dv = 0; m_stray = '0; m_wait = 0;
      end else begin
         m_dv = 0;
         if (!m_busy) begin
            if (cmd_valid && int'(cmd_player) < NP) begin
               m_busy = 1; m_resp = 0; m_tout = 0; m_wait = 0;
               m_sel = cmd_player; m_minb = min_bet;
            end
         end else if (m_tout) begin
            m_dv = 1; m_dplayer = m_sel; m_dact = 3'd0; m_dbet = 8'd0;
            m_dto = 1; m_dill = 0; m_busy = 0;
         end else if (!m_resp) begin
            m_wait++;
            if (valid[m_sel]) begin
               m_resp = 1;
               m_act = action_in[3*int'(m_sel) +: 3];
               m_bet = bet_in[8*int'(m_sel) +: 8];
            end else if (m_wait == TMO) begin
               m_tout = 1;
            end
         end else if (!valid[m_sel]) begin
            m_dv = 1; m_dplayer = m_sel; m_dact = m_act; m_dbet = m_bet; m_dto = 0;
            m_dill = (m_act > 3'd4) || (m_act == 3'd3 && m_bet < m_minb);
            m_busy = 0;
         end
         m_stray = valid;
      end
   end

   logic       e_ready;
   logic [3:0] e_req, e_ack;

   // per-cycle compare against the model plus decision bookkeeping
   always @(negedge clk) begin
      e_ready = !m_busy;
      e_req   = (m_busy && !m_resp && !m_tout) ? (4'b0001 << m_sel) : 4'b0000;
      e_ack   = m_stray;
      if (m_busy && !m_tout) e_ack[m_sel] = m_resp;
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("request_player", 32'(request_player), 32'(e_req));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("decision_valid", 32'(decision_valid), 32'(m_dv));
      if (m_dv) begin
         chk("decision_player", 32'(decision_player), 32'(m_dplayer));
         chk("decision_action", 32'(decision_action), 32'(m_dact));
         chk("decision_bet", 32'(decision_bet), 32'(m_dbet));
         chk("decision_timeout", 32'(decision_timeout), 32'(m_dto));
         chk("decision_illegal", 32'(decision_illegal), 32'(m_dill));
      end
      chk("req_ack_overlap", 32'(request_player & ack), 32'd0);
      if (decision_valid) begin
         dec_count++;
         last_cyc = cyc; last_player = decision_player; last_action = decision_action;
         last_bet = decision_bet; last_to = decision_timeout; last_ill = decision_illegal;
      end
      if (ack[1]) ack1_cnt++;
      if (ack[2]) ack2_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic query(input int p, input logic [7:0] mb, input int dly,
                        input logic [2:0] a, input logic [7:0] b, input int hold);
      cmd_valid = 1; cmd_player = 2'(p); min_bet = mb;
      tick(1);
      acc_cyc = cyc;
      cmd_valid = 0; min_bet = 8'hEE;
      tick(dly);
      valid[p] = 1; action_in[3*p +: 3] = a; bet_in[8*p +: 8] = b;
      tick(1);
      action_in[3*p +: 3] = 3'd7; bet_in[8*p +: 8] = 8'h5A;
      tick(hold - 1);
      valid[p] = 0;
   endtask

   task automatic wait_dec(input int n0, input int lim);
      bit got;
      got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk); #1;
         if (dec_count > n0) got = 1;
      end
      chk("decision_seen", 32'(got), 32'd1);
   endtask

   task automatic chk_dec(input string nm, input int p, input int a, input int b,
                          input int to, input int ill);
      chk({nm, "_player"}, 32'(last_player), p);
      chk({nm, "_action"}, 32'(last_action), a);
      chk({nm, "_bet"}, 32'(last_bet), b);
      chk({nm, "_timeout"}, 32'(last_to), to);
      chk({nm, "_illegal"}, 32'(last_ill), ill);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int n0;
      cmd_valid = 0; cmd_player = 0; min_bet = 0; valid = 0; action_in = 0; bet_in = 0;
      cmd_valid2 = 0; cmd_player2 = 0; valid2 = 0; action2 = 0; bet2 = 0;
      #1 rst = 0;
      tick(2);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_request", 32'(request_player), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_dv", 32'(decision_valid), 32'd0);
      chk("rst_dbet", 32'(decision_bet), 32'd0);
      rst = 1;
      tick(1);

      // normal raise, ack held exactly as long as valid
      n0 = dec_count; ack2_cnt = 0;
      query(2, 8'd20, 4, ACT_RAISE, 8'd40, 3);
      wait_dec(n0, 10);
      chk_dec("normal", 2, 3, 40, 0, 0);
      chk("normal_ack2_cycles", 32'(ack2_cnt), 32'd3);

      // raise below latched minimum
      n0 = dec_count;
      query(0, 8'd50, 2, ACT_RAISE, 8'd10, 3);
      wait_dec(n0, 10);
      chk_dec("ill_raise", 0, 3, 10, 0, 1);

      // undefined action code
      n0 = dec_count;
      query(3, 8'd0, 1, 3'd6, 8'd5, 3);
      wait_dec(n0, 10);
      chk_dec("ill_code", 3, 6, 5, 0, 1);

      // raise equal to minimum is legal
      n0 = dec_count;
      query(1, 8'd30, 0, ACT_RAISE, 8'd30, 4);
      wait_dec(n0, 10);
      chk_dec("raise_eq_min", 1, 3, 30, 0, 0);

      // all-in ignores the minimum
      n0 = dec_count;
      query(2, 8'd100, 3, ACT_ALL_IN, 8'd7, 3);
      wait_dec(n0, 10);
      chk_dec("all_in", 2, 4, 7, 0, 0);

      // timeout: player 1 silent
      n0 = dec_count;
      cmd_valid = 1; cmd_player = 2'd1; min_bet = 8'd0;
      tick(1);
      acc_cyc = cyc; cmd_valid = 0;
      wait_dec(n0, 20);
      chk_dec("timeout", 1, 0, 0, 1, 0);
      chk("timeout_latency", 32'(last_cyc - acc_cyc), 32'd9);

      // late responder is flushed, no decision
      n0 = dec_count; ack1_cnt = 0;
      valid[1] = 1;
      tick(3);
      valid[1] = 0;
      tick(4);
      chk("late_ack1_cycles", 32'(ack1_cnt), 32'd3);
      chk("late_no_decision", 32'(dec_count), 32'(n0));

      // valid on the same edge the timeout would fire
      n0 = dec_count;
      query(3, 8'd0, TMO - 1, ACT_CALL, 8'd7, 3);
      wait_dec(n0, 10);
      chk_dec("simul", 3, 2, 7, 0, 0);
      chk("simul_latency", 32'(last_cyc - acc_cyc), 32'd11);

      // reset during ACK
      cmd_valid = 1; cmd_player = 2'd0; min_bet = 8'd0;
      tick(1);
      cmd_valid = 0; valid[0] = 1; action_in[2:0] = ACT_CHECK;
      tick(2);
      chk("pre_rst_ack0", 32'(ack[0]), 32'd1);
      n0 = dec_count;
      valid[0] = 0; rst = 0;
      #1;
      chk("rst_async_ack", 32'(ack), 32'd0);
      chk("rst_async_req", 32'(request_player), 32'd0);
      tick(1);
      rst = 1;
      tick(1);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      tick(3);
      chk("post_rst_no_decision", 32'(dec_count), 32'(n0));

      // out-of-range player on the three-player instance
      cmd_valid2 = 1; cmd_player2 = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("oor_ready", 32'(cmd_ready2), 32'd1);
         chk("oor_request", 32'(req2), 32'd0);
      end
      cmd_player2 = 2'd2;
      tick(1);
      cmd_valid2 = 0;
      chk("inrange_request", 32'(req2), 32'h4);
      chk("inrange_ready", 32'(cmd_ready2), 32'd0);

      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
